// File: rtl/schmoog_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | schmoog_pkg: shared PS/2 host types, command bytes, frame helper    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package schmoog_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQUEST   = 3'd2,
      SHIFT     = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } ps2_tx_state_e;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

   localparam logic [3:0] PS2_PARITY_EDGE  = 4'd9;
   localparam logic [3:0] PS2_LAST_EDGE    = 4'd10;

   // Bit the host presents after device falling edge n (1..8 data LSB first, 9 parity, 10 stop).
   function automatic logic ps2_frame_bit(input logic [7:0] data_v,
                                          input logic       parity_v,
                                          input logic [3:0] edge_v);
      logic b;
      b = 1'b1;
      if (edge_v >= 4'd1 && edge_v <= 4'd8)
         b = data_v[3'(edge_v - 4'd1)];
      else if (edge_v == PS2_PARITY_EDGE)
         b = parity_v;
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_transmitter_line_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_line_sync: 2-flop synchronizers on PS2_CLK/PS2_DAT plus         |
// | falling-edge detect on the synchronized clock line.                 |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module ps2_line_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic clk_sync_o,
   output logic dat_sync_o,
   output logic clk_fall_o
);

   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic dat_meta_q, dat_sync_q;

   // Reset to the idle (released, high) level so no edge is seen on exit from reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= ps2_clk_i;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= ps2_dat_i;
         dat_sync_q <= dat_meta_q;
      end
   end

   assign clk_sync_o = clk_sync_q;
   assign dat_sync_o = dat_sync_q;
   assign clk_fall_o = clk_prev_q & ~clk_sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_host_transmitter: host-to-device PS/2 byte sender with odd      |
// | parity and ACK check. Optional watchdog: PS2_TX_TIMEOUT_EN.         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module ps2_host_transmitter
   import schmoog_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       send,
   input  logic [7:0] data,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

   if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("ps2_host_transmitter: INHIBIT_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
   end

   logic clk_sync, dat_sync, clk_fall, lines_idle;

   ps2_line_sync u_sync (
      .clock      (clock),
      .reset_n    (reset_n),
      .ps2_clk_i  (ps2_clk_in),
      .ps2_dat_i  (ps2_dat_in),
      .clk_sync_o (clk_sync),
      .dat_sync_o (dat_sync),
      .clk_fall_o (clk_fall)
   );

   assign lines_idle = clk_sync & dat_sync;

   ps2_tx_state_e    state_q;
   logic [7:0]       data_q;
   logic             parity_q;
   logic [3:0]       edge_q, edge_d;
   logic [INH_W-1:0] inh_q;
   logic             clk_oe_q, dat_oe_q, busy_q, done_q, error_q;
   logic             timeout_hit;

   assign edge_d = edge_q + 4'd1;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q;
   logic            wd_active;

   assign wd_active = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);

   // A completing WAIT_IDLE takes priority so done and error can never coincide.
   assign timeout_hit = wd_active && !clk_fall &&
                        (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) &&
                        !(state_q == WAIT_IDLE && lines_idle);

   always_ff @(posedge clock) begin
      if (!reset_n || !wd_active || clk_fall)
         wd_q <= '0;
      else
         wd_q <= wd_q + WD_W'(1);
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         data_q   <= 8'h00;
         parity_q <= 1'b0;
         edge_q   <= 4'd0;
         inh_q    <= '0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         if (timeout_hit) begin
            state_q  <= IDLE;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  if (send) begin
                     data_q   <= data;
                     parity_q <= ~^data;
                     edge_q   <= 4'd0;
                     inh_q    <= '0;
                     busy_q   <= 1'b1;
                     clk_oe_q <= 1'b1;
                     state_q  <= INHIBIT;
                  end
               end
               INHIBIT: begin
                  if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                     clk_oe_q <= 1'b0;
                     dat_oe_q <= 1'b1;
                     state_q  <= REQUEST;
                  end else begin
                     inh_q <= inh_q + INH_W'(1);
                  end
               end
               REQUEST: state_q <= SHIFT;
               SHIFT: begin
                  if (clk_fall) begin
                     edge_q   <= edge_d;
                     dat_oe_q <= ~ps2_frame_bit(data_q, parity_q, edge_d);
                     if (edge_d == PS2_LAST_EDGE)
                        state_q <= ACK;
                  end
               end
               ACK: begin
                  dat_oe_q <= 1'b0;
                  if (clk_fall) begin
                     if (!dat_sync) begin
                        state_q <= WAIT_IDLE;
                     end else begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                     end
                  end
               end
               WAIT_IDLE: begin
                  if (lines_idle) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               default: begin
                  state_q  <= IDLE;
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ps2_host_transmitter: PS/2 device model plus cycle-level         |
// | expectation model of the host transmitter outputs.                  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_ps2_host_transmitter;
   import schmoog_pkg::*;

   localparam int INH   = 10;
   localparam int TMO   = 200;
   localparam int HALF  = 20;
   localparam int NEVER = 1_000_000_000;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       send = 1'b0;
   logic [7:0] data = 8'h00;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;

   // Open-drain lines: low if either side pulls.
   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_host_transmitter #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .send       (send),
      .data       (data),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_done = 0;
   int n_err  = 0;

   // Expectation model: one transaction described by the cycles at which things happen.
   typedef enum int {END_DONE, END_ERR, END_ABORT} end_e;
   bit          tx_on = 1'b0;
   int          c0 = 0;
   int          c_end = NEVER;
   int          react [1:11];
   logic [10:1] frame = '0;
   end_e        end_kind = END_DONE;
   logic [10:1] sampled = '0;

   task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [10:1] make_frame(input logic [7:0] d);
      logic [10:1] f;
      f[8:1] = d;
      f[9]   = ($countones(d) % 2 == 0);
      f[10]  = 1'b1;
      return f;
   endfunction

   function automatic int edges_seen(input int c);
      int k = 0;
      for (int i = 1; i <= 10; i++)
         if (react[i] <= c) k = i;
      return k;
   endfunction

   function automatic logic exp_clk_oe(input int c);
      return tx_on && c >= c0 && c < c0 + INH && c < c_end;
   endfunction

   function automatic logic exp_dat_oe(input int c);
      int k;
      if (!tx_on || c < c0 + INH || c >= c_end) return 1'b0;
      k = edges_seen(c);
      if (k == 0) return 1'b1;
      return ~frame[k];
   endfunction

   function automatic logic exp_busy(input int c);
      return tx_on && c >= c0 && c < c_end;
   endfunction

   // Compare process: every cycle, 1 time unit after the rising edge.
   always @(posedge clock) begin
      cyc = cyc + 1;
      #1;
      checkv("clk_oe", 32'(ps2_clk_oe), 32'(exp_clk_oe(cyc)));
      checkv("dat_oe", 32'(ps2_dat_oe), 32'(exp_dat_oe(cyc)));
      checkv("busy",   32'(busy),       32'(exp_busy(cyc)));
      checkv("done",   32'(done),  32'(tx_on && cyc == c_end && end_kind == END_DONE));
      checkv("error",  32'(error), 32'(tx_on && cyc == c_end && end_kind == END_ERR));
      if (done === 1'b1)  n_done++;
      if (error === 1'b1) n_err++;
   end

   task automatic do_send(input logic [7:0] d);
      @(negedge clock);
      data  = d;
      send  = 1'b1;
      c0    = cyc + 1;
      c_end = NEVER;
      for (int i = 1; i <= 11; i++) react[i] = NEVER;
      frame    = make_frame(d);
      end_kind = END_DONE;
      tx_on    = 1'b1;
      sampled  = '0;
      @(negedge clock);
      send = 1'b0;
      data = ~d;
   endtask

   task automatic poke_send(input logic [7:0] d);
      @(negedge clock);
      data = d;
      send = 1'b1;
      @(negedge clock);
      send = 1'b0;
   endtask

   // Device: clocks the frame, samples host data before each rising edge,
   // answers with ack_bit. last_edge < 11 stops clocking; rst_edge resets the host.
   task automatic device_run(input logic ack_bit, input int last_edge, input int rst_edge);
      int n = 0;
      while (!(ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0) && n < 1000) begin
         @(negedge clock);
         n++;
      end
      checkv("request_seen", 32'(n < 1000), 32'd1);
      if (n >= 1000) return;
      repeat (5) @(negedge clock);
      for (int i = 1; i <= 11; i++) begin
         if (i > last_edge) break;
         dev_clk  = 1'b0;
         react[i] = cyc + 3;
         if (i == rst_edge) begin
            reset_n  = 1'b0;
            c_end    = cyc + 1;
            end_kind = END_ABORT;
            @(negedge clock);
            @(negedge clock);
            reset_n = 1'b1;
            dev_clk = 1'b1;
            dev_dat = 1'b1;
            return;
         end
         if (i == 11 && ack_bit) begin
            c_end    = react[11];
            end_kind = END_ERR;
         end
         if (i == last_edge && last_edge < 11) begin
            c_end    = react[i] + TMO;
            end_kind = END_ERR;
         end
         repeat (HALF) @(negedge clock);
         if (i <= 10) sampled[i] = ps2_dat_in;
         dev_clk = 1'b1;
         if (i == 10) dev_dat = ack_bit;
         repeat (HALF) @(negedge clock);
      end
      if (last_edge == 11 && !ack_bit) c_end = cyc + 3;
      dev_dat = 1'b1;
   endtask

   task automatic wait_end(input string name);
      int n = 0;
      while (cyc <= c_end + 2 && n < 5000) begin
         @(negedge clock);
         n++;
      end
      checkv({name, "_finished"}, 32'(n < 5000), 32'd1);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      checkv("reset_busy",   32'(busy),       32'd0);
      checkv("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
      checkv("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);

      // Set-LEDs command, device ACKs.
      n_done = 0; n_err = 0;
      do_send(PS2_CMD_SET_LEDS);
      device_run(1'b0, 11, 0);
      wait_end("ed");
      for (int i = 1; i <= 10; i++) checkv("ed_bit", 32'(sampled[i]), 32'(frame[i]));
      checkv("ed_frame_literal", 32'(sampled), 32'b11_1110_1101);
      checkv("ed_done_count", n_done, 1);
      checkv("ed_err_count",  n_err,  0);

      // Enable command, device NACKs.
      n_done = 0; n_err = 0;
      do_send(PS2_CMD_ENABLE);
      device_run(1'b1, 11, 0);
      wait_end("f4");
      checkv("f4_frame_literal", 32'(sampled), 32'b10_1111_0100);
      checkv("f4_done_count", n_done, 0);
      checkv("f4_err_count",  n_err,  1);

      // Reset command with sends of 0x00 while busy that must be ignored.
      n_done = 0; n_err = 0;
      do_send(PS2_CMD_RESET);
      fork
         device_run(1'b0, 11, 0);
         begin
            repeat (2) @(negedge clock);
            poke_send(8'h00);
            repeat (80) @(negedge clock);
            poke_send(8'h00);
         end
      join
      wait_end("ff");
      checkv("ff_frame_literal", 32'(sampled), 32'b11_1111_1111);
      checkv("ff_done_count", n_done, 1);

      // Reset at device edge 6, then a clean transfer.
      n_done = 0; n_err = 0;
      do_send(PS2_CMD_SET_LEDS);
      device_run(1'b0, 11, 6);
      wait_end("rst");
      repeat (5) @(negedge clock);
      checkv("rst_no_pulses", n_done + n_err, 0);
      do_send(PS2_CMD_SET_LEDS);
      device_run(1'b0, 11, 0);
      wait_end("ed2");
      checkv("ed2_frame_literal", 32'(sampled), 32'b11_1110_1101);
      checkv("ed2_done_count", n_done, 1);

`ifdef PS2_TX_TIMEOUT_EN
      // Device goes silent after edge 4: watchdog error.
      n_done = 0; n_err = 0;
      do_send(PS2_CMD_ENABLE);
      device_run(1'b0, 4, 0);
      wait_end("tmo");
      checkv("tmo_err_count",  n_err,  1);
      checkv("tmo_done_count", n_done, 0);
`endif

      repeat (5) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
